// File: rtl/insn_fetch_pkg.sv
// Shared CPU/ISA definitions for the instruction fetch stage: bus widths,
// NOP encoding, fetch FSM states and the skid buffer payload layout.
package insn_fetch_pkg;

   localparam int WORD_ADDR_W = 30;
   localparam int WORD_DATA_W = 32;

   typedef logic [WORD_ADDR_W-1:0] word_addr_t;
   typedef logic [WORD_DATA_W-1:0] word_data_t;

   localparam word_data_t ISA_NOP = 32'h0000_0000;

   typedef enum logic {
      ST_REQ  = 1'b0,
      ST_HOLD = 1'b1
   } fetch_state_e;

   typedef struct packed {
      word_data_t insn;
      word_addr_t pc;
   } skid_payload_t;

   localparam int SKID_W = $bits(skid_payload_t);

   // Word addresses wrap at the top of the 30-bit space.
   function automatic word_addr_t next_word(input word_addr_t addr);
      return addr + word_addr_t'(1);
   endfunction

endpackage

// File: rtl/insn_skid_buf.sv
// Single-entry skid buffer that parks one fetched word (instruction plus
// its return pc) while the IF/ID register is stalled.
module insn_skid_buf
   import insn_fetch_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              clear,
   input  logic [SKID_W-1:0] load_data,
   output logic [SKID_W-1:0] data,
   output logic              valid
);

   logic [SKID_W-1:0] data_q,  data_d;
   logic              valid_q, valid_d;

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      if (clear) begin
         data_d  = '0;
         valid_d = 1'b0;
      end else if (load) begin
         data_d  = load_data;
         valid_d = 1'b1;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign data  = data_q;
   assign valid = valid_q;

endmodule

// File: rtl/insn_fetch.sv
// Instruction fetch stage: drives the instruction memory request, fills the
// IF/ID register and parks a returning word in a skid buffer under stall.
module insn_fetch
   import insn_fetch_pkg::*;
#(
   parameter logic [WORD_ADDR_W-1:0] RESET_VECTOR = 30'h0000_0000
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   stall,
   input  logic                   flush,
   input  logic [WORD_ADDR_W-1:0] new_pc,
   input  logic                   br_taken,
   input  logic [WORD_ADDR_W-1:0] br_addr,
   output logic                   imem_req,
   output logic [WORD_ADDR_W-1:0] imem_addr,
   input  logic                   imem_rdy,
   input  logic [WORD_DATA_W-1:0] imem_rd_data,
   output logic [WORD_ADDR_W-1:0] if_pc,
   output logic [WORD_DATA_W-1:0] if_insn,
   output logic                   if_en,
   output logic                   busy
);

   fetch_state_e  state_q,    state_d;
   word_addr_t    fetch_pc_q, fetch_pc_d;
   word_addr_t    if_pc_q,    if_pc_d;
   word_data_t    if_insn_q,  if_insn_d;
   logic          if_en_q,    if_en_d;

   logic          skid_load;
   logic          skid_clear;
   skid_payload_t skid_in;
   skid_payload_t skid_out;
   logic          skid_valid;

   assign skid_in = '{insn: imem_rd_data, pc: next_word(fetch_pc_q)};

   insn_skid_buf u_skid (
      .clk       (clk),
      .reset     (reset),
      .load      (skid_load),
      .clear     (skid_clear),
      .load_data (skid_in),
      .data      (skid_out),
      .valid     (skid_valid)
   );

   // Event priority: flush > stall > br_taken > skid unload > imem_rdy.
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      if_pc_d    = if_pc_q;
      if_insn_d  = if_insn_q;
      if_en_d    = if_en_q;
      skid_load  = 1'b0;
      skid_clear = 1'b0;

      if (flush) begin
         fetch_pc_d = new_pc;
         if_en_d    = 1'b0;
         if_insn_d  = ISA_NOP;
         skid_clear = 1'b1;
         state_d    = ST_REQ;
      end else if (stall) begin
         if (state_q == ST_REQ && imem_rdy) begin
            skid_load  = 1'b1;
            fetch_pc_d = next_word(fetch_pc_q);
            state_d    = ST_HOLD;
         end
      end else if (br_taken) begin
         // A parked word is on the wrong path once decode redirects.
         fetch_pc_d = br_addr;
         if_en_d    = 1'b0;
         if_insn_d  = ISA_NOP;
         skid_clear = 1'b1;
         state_d    = ST_REQ;
      end else if (state_q == ST_HOLD) begin
         if_insn_d  = skid_out.insn;
         if_pc_d    = skid_out.pc;
         if_en_d    = skid_valid;
         skid_clear = 1'b1;
         state_d    = ST_REQ;
      end else if (imem_rdy) begin
         if_insn_d  = imem_rd_data;
         if_pc_d    = next_word(fetch_pc_q);
         if_en_d    = 1'b1;
         fetch_pc_d = next_word(fetch_pc_q);
      end else begin
         if_en_d    = 1'b0;
         if_insn_d  = ISA_NOP;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_REQ;
         fetch_pc_q <= RESET_VECTOR;
         if_pc_q    <= RESET_VECTOR;
         if_insn_q  <= ISA_NOP;
         if_en_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         if_pc_q    <= if_pc_d;
         if_insn_q  <= if_insn_d;
         if_en_q    <= if_en_d;
      end
   end

   assign imem_req  = (state_q == ST_REQ) && !reset;
   assign imem_addr = fetch_pc_q;
   assign busy      = ((state_q == ST_REQ) && !imem_rdy) || (state_q == ST_HOLD);
   assign if_pc     = if_pc_q;
   assign if_insn   = if_insn_q;
   assign if_en     = if_en_q;

endmodule

// File: tb/tb_insn_fetch.sv
// Directed bench for insn_fetch: expected IF/ID contents are queued as each
// step is driven and compared after the clock edge; a second instance covers wrap.
module tb_insn_fetch;

   logic        clk = 1'b0;
   logic        reset, stall, flush, br_taken, imem_rdy;
   logic [29:0] new_pc, br_addr;
   logic        imem_req, if_en, busy;
   logic [29:0] imem_addr, if_pc;
   logic [31:0] imem_rd_data, if_insn;

   logic        imem_req_b, if_en_b, busy_b;
   logic [29:0] imem_addr_b, if_pc_b;
   logic [31:0] imem_rd_data_b, if_insn_b;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       tag;
      logic        en;
      logic [31:0] insn;
      logic [29:0] pc;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   // Memory image: mem[k] = k + 0x100, answered combinationally.
   assign imem_rd_data   = {2'b00, imem_addr}   + 32'h100;
   assign imem_rd_data_b = {2'b00, imem_addr_b} + 32'h100;

   insn_fetch dut (
      .clk          (clk),
      .reset        (reset),
      .stall        (stall),
      .flush        (flush),
      .new_pc       (new_pc),
      .br_taken     (br_taken),
      .br_addr      (br_addr),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_rdy     (imem_rdy),
      .imem_rd_data (imem_rd_data),
      .if_pc        (if_pc),
      .if_insn      (if_insn),
      .if_en        (if_en),
      .busy         (busy)
   );

   insn_fetch #(.RESET_VECTOR(30'h3FFF_FFFF)) dut_wrap (
      .clk          (clk),
      .reset        (reset),
      .stall        (1'b0),
      .flush        (1'b0),
      .new_pc       (30'h0),
      .br_taken     (1'b0),
      .br_addr      (30'h0),
      .imem_req     (imem_req_b),
      .imem_addr    (imem_addr_b),
      .imem_rdy     (1'b1),
      .imem_rd_data (imem_rd_data_b),
      .if_pc        (if_pc_b),
      .if_insn      (if_insn_b),
      .if_en        (if_en_b),
      .busy         (busy_b)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic expect_ifid(input string tag, input logic en, input logic [31:0] insn,
                              input logic [29:0] pc);
      exp_t e;
      e.tag  = tag;
      e.en   = en;
      e.insn = insn;
      e.pc   = pc;
      sb.push_back(e);
   endtask

   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         chk({e.tag, ".if_en"},   64'(if_en),   64'(e.en));
         chk({e.tag, ".if_insn"}, 64'(if_insn), 64'(e.insn));
         chk({e.tag, ".if_pc"},   64'(if_pc),   64'(e.pc));
      end
   endtask

   initial begin
      reset    = 1'b1;
      stall    = 1'b0;
      flush    = 1'b0;
      br_taken = 1'b0;
      imem_rdy = 1'b1;
      new_pc   = '0;
      br_addr  = '0;

      // Reset state.
      tick();
      expect_ifid("reset", 1'b0, 32'h0, 30'h0);
      tick();
      chk("reset.imem_req",   64'(imem_req),   64'(0));
      chk("reset.imem_addr",  64'(imem_addr),  64'(0));
      chk("reset.wrap_if_pc", 64'(if_pc_b),    64'h3FFF_FFFF);
      chk("reset.wrap_req",   64'(imem_req_b), 64'(0));

      // Back-to-back fetch with imem_rdy held high.
      reset = 1'b0;
      #1;
      chk("run.imem_req",  64'(imem_req),  64'(1));
      chk("run.imem_addr", 64'(imem_addr), 64'(0));
      chk("run.busy",      64'(busy),      64'(0));
      expect_ifid("fetch0", 1'b1, 32'h100, 30'd1);
      tick();
      chk("wrap.if_pc",     64'(if_pc_b),     64'(0));
      chk("wrap.if_insn",   64'(if_insn_b),   64'h4000_00FF);
      chk("wrap.if_en",     64'(if_en_b),     64'(1));
      chk("wrap.imem_addr", 64'(imem_addr_b), 64'(0));
      expect_ifid("fetch1", 1'b1, 32'h101, 30'd2);
      tick();
      expect_ifid("fetch2", 1'b1, 32'h102, 30'd3);
      tick();
      chk("wrap.if_pc2", 64'(if_pc_b), 64'(2));

      // Memory not ready for two cycles at fetch_pc=3.
      imem_rdy = 1'b0;
      #1;
      chk("wait0.busy", 64'(busy),      64'(1));
      chk("wait0.addr", 64'(imem_addr), 64'(3));
      expect_ifid("wait0", 1'b0, 32'h0, 30'd3);
      tick();
      chk("wait1.busy", 64'(busy),      64'(1));
      chk("wait1.addr", 64'(imem_addr), 64'(3));
      chk("wait1.req",  64'(imem_req),  64'(1));
      expect_ifid("wait1", 1'b0, 32'h0, 30'd3);
      tick();
      imem_rdy = 1'b1;
      expect_ifid("resume3", 1'b1, 32'h103, 30'd4);
      tick();
      expect_ifid("fetch4", 1'b1, 32'h104, 30'd5);
      tick();

      // Stall three cycles with imem_rdy at fetch_pc=5.
      stall = 1'b1;
      chk("stall.addr", 64'(imem_addr), 64'(5));
      expect_ifid("stall0", 1'b1, 32'h104, 30'd5);
      tick();
      chk("hold.req",  64'(imem_req), 64'(0));
      chk("hold.busy", 64'(busy),     64'(1));
      expect_ifid("stall1", 1'b1, 32'h104, 30'd5);
      tick();
      expect_ifid("stall2", 1'b1, 32'h104, 30'd5);
      tick();
      chk("hold2.req", 64'(imem_req), 64'(0));
      stall = 1'b0;
      expect_ifid("unpark5", 1'b1, 32'h105, 30'd6);
      tick();
      chk("after_hold.addr", 64'(imem_addr), 64'(6));
      expect_ifid("fetch6", 1'b1, 32'h106, 30'd7);
      tick();
      expect_ifid("fetch7", 1'b1, 32'h107, 30'd8);
      tick();
      expect_ifid("fetch8", 1'b1, 32'h108, 30'd9);
      tick();

      // Branch to 0x40 at fetch_pc=9.
      br_taken = 1'b1;
      br_addr  = 30'h40;
      expect_ifid("branch", 1'b0, 32'h0, 30'd9);
      tick();
      br_taken = 1'b0;
      chk("branch.addr", 64'(imem_addr), 64'h40);
      expect_ifid("target", 1'b1, 32'h140, 30'h41);
      tick();

      // Branch during stall is ignored; stall without rdy holds everything.
      stall    = 1'b1;
      br_taken = 1'b1;
      br_addr  = 30'h200;
      imem_rdy = 1'b0;
      expect_ifid("stall_nordy", 1'b1, 32'h140, 30'h41);
      tick();
      chk("stall_nordy.addr", 64'(imem_addr), 64'h41);
      chk("stall_nordy.req",  64'(imem_req),  64'(1));
      br_taken = 1'b0;

      // Park a word, then flush with stall still high.
      imem_rdy = 1'b1;
      expect_ifid("park41", 1'b1, 32'h140, 30'h41);
      tick();
      chk("park41.req", 64'(imem_req), 64'(0));
      flush  = 1'b1;
      new_pc = 30'h80;
      expect_ifid("flush", 1'b0, 32'h0, 30'h41);
      tick();
      chk("flush.addr", 64'(imem_addr), 64'h80);
      chk("flush.req",  64'(imem_req),  64'(1));
      flush = 1'b0;
      stall = 1'b0;
      expect_ifid("post_flush", 1'b1, 32'h180, 30'h81);
      tick();

      // Reset mid-operation with a word parked.
      stall = 1'b1;
      expect_ifid("park81", 1'b1, 32'h180, 30'h81);
      tick();
      reset = 1'b1;
      stall = 1'b0;
      expect_ifid("mid_reset", 1'b0, 32'h0, 30'h0);
      tick();
      chk("mid_reset.req", 64'(imem_req), 64'(0));
      reset = 1'b0;
      #1;
      chk("post_reset.req", 64'(imem_req), 64'(1));
      expect_ifid("post_reset", 1'b1, 32'h100, 30'd1);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/insn_fetch.md
INSN_FETCH -- requirements
Module: insn_fetch

Interface
- REQ-001 Parameter RESET_VECTOR, default 30'h0000_0000, word address of the first fetch after reset.
- REQ-002 clk  in  1  single clock; all state updates on rising edge.
- REQ-003 reset  in  1  synchronous, active-high.
- REQ-004 stall  in  1  hold IF/ID pipeline register.
- REQ-005 flush  in  1  discard in-flight fetch and redirect to new_pc.
- REQ-006 new_pc  in  30  flush target word address.
- REQ-007 br_taken  in  1  branch redirect from decode.
- REQ-008 br_addr  in  30  branch target word address.
- REQ-009 imem_req  out  1  instruction fetch request.
- REQ-010 imem_addr  out  30  fetch word address.
- REQ-011 imem_rdy  in  1  imem_rd_data valid for the current imem_addr this cycle.
- REQ-012 imem_rd_data  in  32  instruction word.
- REQ-013 if_pc  out  30  fetched word address + 1.
- REQ-014 if_insn  out  32  fetched instruction.
- REQ-015 if_en  out  1  IF/ID contents valid.
- REQ-016 busy  out  1  fetch cannot deliver this cycle.

Function
- REQ-017 The block SHALL hold fetch_pc (30 bit) and a 2-state FSM: ST_REQ (request outstanding) and ST_HOLD (word parked in the skid buffer).
- REQ-018 imem_req SHALL be 1 exactly in ST_REQ outside reset; imem_addr SHALL equal fetch_pc and SHALL stay stable until imem_rdy, flush or br_taken.
- REQ-019 Event priority SHALL be: reset > flush > stall > br_taken > imem_rdy.
- REQ-020 flush: fetch_pc<=new_pc, if_en<=0, if_insn<=NOP (32'h0), skid cleared, state<=ST_REQ, imem_rdy that cycle discarded; applies in both states and regardless of stall.
- REQ-021 stall in ST_REQ with imem_rdy: word captured into skid (insn, fetch_pc+1), fetch_pc<=fetch_pc+1, state<=ST_HOLD; if_pc/if_insn/if_en unchanged.
- REQ-022 stall without imem_rdy: IF/ID outputs and fetch_pc unchanged; request remains asserted.
- REQ-023 ST_HOLD with stall=0: IF/ID loaded from skid, if_en<=1, state<=ST_REQ; no request that cycle.
- REQ-024 br_taken (no stall, no flush): fetch_pc<=br_addr, if_en<=0, if_insn<=NOP, imem_rdy that cycle discarded; br_taken during stall SHALL be ignored.
- REQ-025 ST_REQ, imem_rdy=1, no higher event: if_insn<=imem_rd_data, if_pc<=fetch_pc+1, if_en<=1, fetch_pc<=fetch_pc+1.
- REQ-026 ST_REQ, imem_rdy=0, no stall: bubble inserted, if_en<=0, if_insn<=NOP, if_pc unchanged.
- REQ-027 Throughput SHALL be one instruction per cycle with imem_rdy held 1; latency request-to-if_en is 1 cycle.
- REQ-028 fetch_pc and if_pc increments SHALL wrap 30'h3FFF_FFFF -> 30'h0.
- REQ-029 busy SHALL be combinational: (ST_REQ & ~imem_rdy) | ST_HOLD.

Reset
- REQ-030 On reset: fetch_pc=RESET_VECTOR, if_pc=RESET_VECTOR, if_insn=NOP, if_en=0, skid cleared, state=ST_REQ, imem_req=0 during the reset cycle.
- REQ-031 Reset asserted mid-operation SHALL drop any parked or in-flight word; first request in cycle after reset deasserts.

Structure
- REQ-032 WordAddrBus/WordDataBus widths, ISA NOP encoding and FSM state encodings SHALL live in the shared cpu/isa headers.
- REQ-033 The skid buffer SHALL be one sub-module, insn_skid_buf (load, clear, 62-bit payload, valid).

Verification
- REQ-034 Reset release, imem_rdy=1 constant, mem[k]=k+0x100 -> if_insn 0x100,0x101,0x102 on consecutive cycles, if_pc 1,2,3, if_en=1.
- REQ-035 stall high 3 cycles while imem_rdy=1 at fetch_pc=5 -> IF/ID frozen, imem_req=0 in ST_HOLD, after release if_insn=mem[5], if_pc=6, then mem[6].
- REQ-036 br_taken with br_addr=0x40 at fetch_pc=9 -> one bubble (if_en=0, if_insn=0), next imem_addr=0x40.
- REQ-037 flush with new_pc=0x80 and stall simultaneously in ST_HOLD -> skid dropped, if_en=0, imem_addr=0x80 next cycle.
- REQ-038 RESET_VECTOR=30'h3FFF_FFFF, imem_rdy=1 -> first if_pc=0, second imem_addr=0.
- REQ-039 imem_rdy=0 for 2 cycles at fetch_pc=3 -> if_en=0 both cycles, busy=1, imem_addr held 3.
